// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver and its consumer.
// The receiver drives rx_data/rx_valid; the consumer answers with rx_ready.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Bit timing re-aligns to each start edge; a byte is offered one clock after the stop-bit sample.
// Single-byte holding register: a byte that arrives while it is still full is dropped and sets the sticky overrun flag.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int CNT_SIZE     = 11
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       rx,
  uart_rx_if.master  rx_if,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [CNT_SIZE-1:0] HALF_CNT = CNT_SIZE'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_SIZE-1:0] BIT_CNT  = CNT_SIZE'(CLKS_PER_BIT - 1);

  logic                rx_sync1_q, rx_sync1_d;
  logic                rx_s_q, rx_s_d;
  logic                rx_s_dly_q, rx_s_dly_d;
  state_t              state_q, state_d;
  logic [CNT_SIZE-1:0] cnt_q, cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;
  logic                fall;
  logic                deliver;
  logic                xfer;

  always_comb begin
    rx_sync1_d  = rx;
    rx_s_d      = rx_sync1_q;
    rx_s_dly_d  = rx_s_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    deliver     = 1'b0;
    fall        = rx_s_dly_q & ~rx_s_q;
    xfer        = valid_q & rx_if.rx_ready;

    case (state_q)
      IDLE: begin
        // Edge-triggered only, so a line stuck low (break) cannot re-arm the receiver.
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_SIZE'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_CNT) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_SIZE'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d       = '0;
          state_d     = IDLE;
          deliver     = rx_s_q;
          frame_err_d = ~rx_s_q;
        end else begin
          cnt_d = cnt_q + CNT_SIZE'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A delivery in the same cycle as a transfer refills the register without overrun.
    if (deliver) begin
      if (!valid_q || xfer) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync1_q  <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_s_dly_q  <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_sync1_q  <= rx_sync1_d;
      rx_s_q      <= rx_s_d;
      rx_s_dly_q  <= rx_s_dly_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign frame_err      = frame_err_q;
  assign overrun        = overrun_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames for uart_rx at 16 clocks per bit, checked against a byte-level model.
module tb_uart_rx;
  localparam int CPB = 16;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic rx     = 1'b1;
  logic frame_err, overrun, busy;

  uart_rx_if u_if();

  uart_rx #(.CLKS_PER_BIT(CPB), .CNT_SIZE(5)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_if     (u_if.master),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Observation counters, written only by this monitor.
  int unsigned rise_cyc = 0;
  int          valid_hi = 0, fe_hi = 0, busy_hi = 0, got_n = 0;
  logic        valid_prev = 1'b0;
  logic [7:0]  got_mem [0:255];

  always @(negedge clk_in) begin
    if (u_if.rx_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = u_if.rx_valid;
    if (u_if.rx_valid) valid_hi++;
    if (frame_err) fe_hi++;
    if (busy) busy_hi++;
    if (u_if.rx_valid && u_if.rx_ready) begin
      got_mem[got_n] = u_if.rx_data;
      got_n++;
    end
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int unsigned fall_cyc = 0;
  int rd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    fall_cyc = cyc;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    if (!stop) begin
      rx = 1'b1;
      tick(CPB);
    end
  endtask

  task automatic chk_got(input string tag, input logic [7:0] exp);
    chk(tag, 32'(got_mem[rd]), 32'(exp));
    rd++;
  endtask

  initial begin
    int vh0, fe0, bh0, n0, nbad;
    logic [7:0] d;
    logic       st;
    logic [7:0] exp_q[$];

    u_if.rx_ready = 1'b0;
    tick(3);
    chk("rst_data", 32'(u_if.rx_data), 32'h0);
    chk("rst_valid", 32'(u_if.rx_valid), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick(5);

    // 1: single byte, consumer not ready
    fe0 = fe_hi;
    send_frame(8'hA5, 1'b1);
    chk("t1_latency", rise_cyc - fall_cyc, 32'(2 + 1 + 8 + 9 * CPB));
    chk("t1_data", 32'(u_if.rx_data), 32'hA5);
    chk("t1_valid", 32'(u_if.rx_valid), 32'h1);
    chk("t1_ferr", 32'(fe_hi - fe0), 32'h0);
    chk("t1_ovr", 32'(overrun), 32'h0);
    u_if.rx_ready = 1'b1;
    tick(2);
    chk_got("t1_xfer", 8'hA5);
    chk("t1_drained", 32'(u_if.rx_valid), 32'h0);

    // 2: back-to-back with ready held
    vh0 = valid_hi; n0 = got_n;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(2);
    chk("t2_count", 32'(got_n - n0), 32'h2);
    chk_got("t2_byte0", 8'h00);
    chk_got("t2_byte1", 8'hFF);
    chk("t2_pulses", 32'(valid_hi - vh0), 32'h2);
    chk("t2_ovr", 32'(overrun), 32'h0);

    // 3: framing error, then a good byte
    fe0 = fe_hi; vh0 = valid_hi; n0 = got_n;
    send_frame(8'h3C, 1'b0);
    chk("t3_ferr_pulse", 32'(fe_hi - fe0), 32'h1);
    chk("t3_no_valid", 32'(valid_hi - vh0), 32'h0);
    chk("t3_no_byte", 32'(got_n - n0), 32'h0);
    send_frame(8'h42, 1'b1);
    tick(2);
    chk_got("t3_recover", 8'h42);

    // 4: short low glitch
    bh0 = busy_hi; vh0 = valid_hi; fe0 = fe_hi;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    chk("t4_busy_le8", 32'((busy_hi - bh0) <= 8), 32'h1);
    chk("t4_busy_seen", 32'((busy_hi - bh0) > 0), 32'h1);
    chk("t4_no_valid", 32'(valid_hi - vh0), 32'h0);
    chk("t4_no_ferr", 32'(fe_hi - fe0), 32'h0);

    // 5: overrun
    u_if.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(2);
    chk("t5_keep_old", 32'(u_if.rx_data), 32'h11);
    chk("t5_valid", 32'(u_if.rx_valid), 32'h1);
    chk("t5_ovr_set", 32'(overrun), 32'h1);
    u_if.rx_ready = 1'b1;
    tick(1);
    u_if.rx_ready = 1'b0;
    tick(2);
    chk("t5_valid_clr", 32'(u_if.rx_valid), 32'h0);
    chk("t5_ovr_sticky", 32'(overrun), 32'h1);
    chk_got("t5_xfer", 8'h11);

    // 6: reset in the middle of data bit 4
    d = 8'hC3;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = d[4];
    tick(CPB / 2);
    rst_n = 1'b0;
    rx = 1'b1;
    tick(2);
    chk("t6_rst_data", 32'(u_if.rx_data), 32'h0);
    chk("t6_rst_valid", 32'(u_if.rx_valid), 32'h0);
    chk("t6_rst_ferr", 32'(frame_err), 32'h0);
    chk("t6_rst_ovr", 32'(overrun), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    vh0 = valid_hi; n0 = got_n;
    tick(12 * CPB);
    chk("t6_no_partial", 32'(valid_hi - vh0), 32'h0);
    u_if.rx_ready = 1'b1;
    send_frame(8'h5A, 1'b1);
    tick(2);
    chk("t6_count", 32'(got_n - n0), 32'h1);
    chk_got("t6_byte", 8'h5A);

    // 7: random frames, random stop validity and idle gaps
    fe0 = fe_hi; n0 = got_n; nbad = 0;
    for (int k = 0; k < 10; k++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      if (st) exp_q.push_back(d);
      else nbad++;
      send_frame(d, st);
      tick($urandom_range(0, 20));
    end
    tick(4);
    chk("t7_count", 32'(got_n - n0), 32'(exp_q.size()));
    chk("t7_ferr", 32'(fe_hi - fe0), 32'(nbad));
    foreach (exp_q[j]) chk_got($sformatf("t7_byte%0d", j), exp_q[j]);
    chk("t7_ovr", 32'(overrun), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
